// File: rtl/kernel_seq.sv
// kernel_seq: read-side sequencer for the per-group kernel memory.
// Define KERNEL_SEQ_LAST_EN to build the per-pass counter that drives ker_last.
module kernel_seq #(
    parameter int GROUP_NB   = 4,
    parameter int KER_WIDTH  = 16,
    parameter int MEM_AWIDTH = 16,
    parameter int RPT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MEM_AWIDTH-1:0]         cfg_start,
    input  logic [MEM_AWIDTH-1:0]         cfg_end,
    input  logic [RPT_WIDTH-1:0]          cfg_repeat,
    input  logic                          cfg_val,
    output logic                          cfg_rdy,
    output logic [MEM_AWIDTH-1:0]         mem_cfg_start,
    output logic [MEM_AWIDTH-1:0]         mem_cfg_end,
    output logic                          mem_cfg_set,
    input  logic [GROUP_NB*KER_WIDTH-1:0] mem_data,
    output logic                          mem_pop,
    output logic [GROUP_NB*KER_WIDTH-1:0] ker_data,
    output logic                          ker_val,
    input  logic                          ker_rdy,
    output logic                          ker_last,
    output logic                          ker_end,
    output logic                          done
);
    localparam int DW = GROUP_NB * KER_WIDTH;
    localparam int TW = MEM_AWIDTH + RPT_WIDTH + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]            state;
    logic                  cfg_rdy_q;
    logic                  cfg_set_q;
    logic                  done_q;
    logic [MEM_AWIDTH-1:0] start_q;
    logic [MEM_AWIDTH-1:0] end_q;
    logic [RPT_WIDTH-1:0]  rpt_q;
    logic [TW-1:0]         remain;

    // Two-entry output FIFO plus the word whose read is in flight.
    logic [DW-1:0] head_data, tail_data;
    logic          head_last, head_end, tail_last, tail_end;
    logic [1:0]    count;
    logic          fly, fly_last, fly_end;

    logic [MEM_AWIDTH-1:0] diff;
    logic [MEM_AWIDTH:0]   pass_len;
    logic [RPT_WIDTH-1:0]  passes;
    logic [TW-1:0]         total;
    logic [2:0]            credit;
    logic                  out_val, out_last, out_end;
    logic [DW-1:0]         out_data;
    logic                  deq, deq_fifo, push, pop, pop_last, pop_end;

    assign diff     = end_q - start_q;
    assign pass_len = {1'b0, diff} + {{MEM_AWIDTH{1'b0}}, 1'b1};
    assign passes   = (rpt_q == {RPT_WIDTH{1'b0}}) ? {{(RPT_WIDTH-1){1'b0}}, 1'b1} : rpt_q;
    assign total    = TW'(pass_len) * TW'(passes);

    // Output view: FIFO head when stored, otherwise the in-flight word straight from memory.
    always_comb begin
        out_val  = (count != 2'd0) || fly;
        out_data = {DW{1'b0}};
        out_last = 1'b0;
        out_end  = 1'b0;
        if (count != 2'd0) begin
            out_data = head_data;
            out_last = head_last;
            out_end  = head_end;
        end else if (fly) begin
            out_data = mem_data;
            out_last = fly_last;
            out_end  = fly_end;
        end else begin
            out_data = {DW{1'b0}};
        end
    end

    assign deq      = out_val && ker_rdy;
    assign deq_fifo = deq && (count != 2'd0);
    assign push     = fly && !((count == 2'd0) && deq);
    assign credit   = {1'b0, count} + {2'b00, fly} - {2'b00, deq};
    assign pop      = (state == STREAM) && (remain != {TW{1'b0}}) && (credit < 3'd2);
    assign pop_end  = (remain == TW'(1));

`ifdef KERNEL_SEQ_LAST_EN
    logic [MEM_AWIDTH:0] word_cnt;
    assign pop_last = ((word_cnt + {{MEM_AWIDTH{1'b0}}, 1'b1}) == pass_len);

    // Position of the next pop within the current pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= {(MEM_AWIDTH+1){1'b0}};
        end else if (state == LOAD) begin
            word_cnt <= {(MEM_AWIDTH+1){1'b0}};
        end else if (pop) begin
            word_cnt <= pop_last ? {(MEM_AWIDTH+1){1'b0}} : word_cnt + {{MEM_AWIDTH{1'b0}}, 1'b1};
        end
    end
`else
    assign pop_last = 1'b0;
`endif

    // Job sequencing: accept, program the read window, count pops, finish on the end word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cfg_rdy_q <= 1'b1;
            cfg_set_q <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= {MEM_AWIDTH{1'b0}};
            end_q     <= {MEM_AWIDTH{1'b0}};
            rpt_q     <= {RPT_WIDTH{1'b0}};
            remain    <= {TW{1'b0}};
        end else begin
            cfg_set_q <= 1'b0;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_val) begin
                        start_q   <= cfg_start;
                        end_q     <= cfg_end;
                        rpt_q     <= cfg_repeat;
                        cfg_rdy_q <= 1'b0;
                        cfg_set_q <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    remain <= total;
                    state  <= STREAM;
                end
                STREAM: begin
                    if (pop) begin
                        remain <= remain - TW'(1);
                        if (pop_end) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (deq && out_end) begin
                        cfg_rdy_q <= 1'b1;
                        done_q    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage; a word dequeued while still in flight bypasses storage entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            fly       <= 1'b0;
            fly_last  <= 1'b0;
            fly_end   <= 1'b0;
            head_data <= {DW{1'b0}};
            tail_data <= {DW{1'b0}};
            head_last <= 1'b0;
            head_end  <= 1'b0;
            tail_last <= 1'b0;
            tail_end  <= 1'b0;
        end else begin
            fly      <= pop;
            fly_last <= pop && pop_last;
            fly_end  <= pop && pop_end;
            case (count)
                2'd0: begin
                    if (push) begin
                        head_data <= mem_data;
                        head_last <= fly_last;
                        head_end  <= fly_end;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && deq_fifo) begin
                        head_data <= mem_data;
                        head_last <= fly_last;
                        head_end  <= fly_end;
                    end else if (push) begin
                        tail_data <= mem_data;
                        tail_last <= fly_last;
                        tail_end  <= fly_end;
                        count     <= 2'd2;
                    end else if (deq_fifo) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (deq_fifo) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        head_end  <= tail_end;
                        if (push) begin
                            tail_data <= mem_data;
                            tail_last <= fly_last;
                            tail_end  <= fly_end;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: begin
                    count <= 2'd0;
                end
            endcase
        end
    end

    assign cfg_rdy       = cfg_rdy_q;
    assign mem_cfg_set   = cfg_set_q;
    assign mem_cfg_start = start_q;
    assign mem_cfg_end   = end_q;
    assign done          = done_q;
    assign mem_pop       = pop;
    assign ker_val       = out_val;
    assign ker_data      = out_data;
    assign ker_last      = out_last;
    assign ker_end       = out_end;
endmodule

// File: tb/tb_kernel_seq.sv
// Self-checking bench for kernel_seq: behavioural memory, randomized jobs and stalls,
// expected word stream built from address-range / pass-count arithmetic.
module tb_kernel_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_start = 16'd0, cfg_end = 16'd0, cfg_repeat = 16'd0;
    logic        cfg_val = 1'b0;
    logic        cfg_rdy;
    logic [15:0] mem_cfg_start, mem_cfg_end;
    logic        mem_cfg_set;
    logic [63:0] mem_data = 64'd0;
    logic        mem_pop;
    logic [63:0] ker_data;
    logic        ker_val;
    logic        ker_rdy = 1'b0;
    logic        ker_last, ker_end, done;

`ifdef KERNEL_SEQ_LAST_EN
    localparam bit LAST_ON = 1'b1;
`else
    localparam bit LAST_ON = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] salt = 16'h0;
    logic [15:0] rptr = 16'd0, wstart = 16'd0, wend = 16'd0;

    kernel_seq dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_repeat(cfg_repeat),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
        .mem_cfg_start(mem_cfg_start), .mem_cfg_end(mem_cfg_end), .mem_cfg_set(mem_cfg_set),
        .mem_data(mem_data), .mem_pop(mem_pop),
        .ker_data(ker_data), .ker_val(ker_val), .ker_rdy(ker_rdy),
        .ker_last(ker_last), .ker_end(ker_end), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] word_of(input logic [15:0] a);
        return {a ^ salt, ~a, a + 16'h1357, a};
    endfunction

    // Kernel memory: window load, one-cycle read latency, rewinds to start after end.
    always @(posedge clk) begin
        if (mem_cfg_set) begin
            rptr   <= mem_cfg_start;
            wstart <= mem_cfg_start;
            wend   <= mem_cfg_end;
        end else if (mem_pop) begin
            mem_data <= word_of(rptr);
            rptr     <= (rptr == wend) ? wstart : rptr + 16'd1;
        end
    end

    task automatic run_job(input logic [15:0] s, input logic [15:0] e, input logic [15:0] rep,
                           input int rdy_pct, input int stop_after, input string name);
        int exp_addr[$];
        bit exp_last[$];
        bit exp_end[$];
        int len, np, n, rel, t0, acc, pops, sets, end_rel, first_rel;
        bit finished, stopped, prev_stall, pv_last, pv_end, want_last;
        logic [63:0] pv_data;
        len = int'(16'(e - s)) + 1;
        np  = (rep == 16'd0) ? 1 : int'(rep);
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back((int'(s) + i) % 65536);
                exp_last.push_back(i == len - 1);
                exp_end.push_back((p == np - 1) && (i == len - 1));
            end
        end
        n = exp_addr.size();
        acc = 0; pops = 0; sets = 0; end_rel = -10; first_rel = -1;
        finished = 0; stopped = 0; prev_stall = 0; pv_data = 64'd0; pv_last = 0; pv_end = 0;
        salt = 16'($urandom);
        @(negedge clk);
        cfg_start = s; cfg_end = e; cfg_repeat = rep; cfg_val = 1'b1; ker_rdy = 1'b0;
        #1;
        total++;
        if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL %s accept: cfg_rdy=%b want 1", name, cfg_rdy); end
        t0 = cyc;
        for (int c = 0; c < 30 * n + 40; c++) begin
            @(negedge clk);
            cfg_val = ($urandom_range(3, 0) == 0);
            cfg_start = 16'($urandom); cfg_end = 16'($urandom); cfg_repeat = 16'($urandom);
            ker_rdy = ($urandom_range(99, 0) < rdy_pct);
            #1;
            rel = cyc - t0;
            if (!done) begin
                total++;
                if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL %s busy_rdy: cycle %0d cfg_rdy=%b want 0", name, rel, cfg_rdy); end
            end
            if (mem_cfg_set) begin
                sets++;
                total++;
                if (rel != 1 || mem_cfg_start !== s || mem_cfg_end !== e) begin
                    bad++;
                    $display("FAIL %s cfg_set: cycle %0d start=%h end=%h want cycle 1 start=%h end=%h", name, rel, mem_cfg_start, mem_cfg_end, s, e);
                end
            end
            total++;
            if ((pops - acc) + int'(mem_pop) - int'(ker_val && ker_rdy) > 2 || pops + int'(mem_pop) > n || (mem_pop && rel < 2)) begin
                bad++;
                $display("FAIL %s pop_credit: cycle %0d pop=%b outstanding=%0d issued=%0d want <=2 outstanding, <=%0d issued, cycle>=2", name, rel, mem_pop, pops - acc, pops, n);
            end
            pops += int'(mem_pop);
            if (ker_val === 1'b1 && first_rel < 0) begin
                first_rel = rel;
                total++;
                if (rel != 3) begin bad++; $display("FAIL %s first_val: cycle %0d want 3", name, rel); end
            end
            if (prev_stall) begin
                total++;
                if (ker_val !== 1'b1 || ker_data !== pv_data || ker_last !== pv_last || ker_end !== pv_end) begin
                    bad++;
                    $display("FAIL %s stall_hold: val=%b data=%h last=%b end=%b want 1 %h %b %b", name, ker_val, ker_data, ker_last, ker_end, pv_data, pv_last, pv_end);
                end
            end
            if (rdy_pct == 100 && first_rel >= 0 && acc < n) begin
                total++;
                if (ker_val !== 1'b1) begin bad++; $display("FAIL %s throughput: cycle %0d ker_val=%b want 1", name, rel, ker_val); end
            end
            if (ker_val === 1'b1 && ker_rdy) begin
                total++;
                if (acc >= n) begin
                    bad++;
                    $display("FAIL %s extra_word: got data=%h after %0d words, want none", name, ker_data, n);
                end else begin
                    want_last = LAST_ON && exp_last[acc];
                    if (ker_data !== word_of(16'(exp_addr[acc])) || ker_last !== want_last || ker_end !== exp_end[acc]) begin
                        bad++;
                        $display("FAIL %s word%0d: data=%h last=%b end=%b want %h %b %b (addr %h)", name, acc, ker_data, ker_last, ker_end, word_of(16'(exp_addr[acc])), want_last, exp_end[acc], exp_addr[acc]);
                    end
                    if (exp_end[acc]) end_rel = rel;
                    acc++;
                end
            end
            prev_stall = (ker_val === 1'b1) && !ker_rdy;
            pv_data = ker_data; pv_last = ker_last; pv_end = ker_end;
            if (done) begin
                cfg_val = 1'b0;
                finished = 1;
                total++;
                if (acc != n || rel != end_rel + 1 || cfg_rdy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s done: cycle %0d words=%0d cfg_rdy=%b want cycle %0d words=%0d cfg_rdy=1", name, rel, acc, cfg_rdy, end_rel + 1, n);
                end
            end
            if (stop_after > 0 && acc == stop_after) begin
                cfg_val = 1'b0;
                stopped = 1;
            end
            if (finished || stopped) break;
        end
        cfg_val = 1'b0;
        if (stop_after == 0) begin
            total++;
            if (!finished || sets != 1) begin
                bad++;
                $display("FAIL %s completion: done_seen=%b cfg_sets=%0d words=%0d want done, 1 set, %0d words", name, finished, sets, acc, n);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({cfg_rdy, mem_cfg_set, mem_pop, ker_val, ker_last, ker_end, done} !== 7'b1000000 ||
            ker_data !== 64'd0 || mem_cfg_start !== 16'd0 || mem_cfg_end !== 16'd0) begin
            bad++;
            $display("FAIL reset_values: flags=%b data=%h start=%h end=%h want 1000000 0 0 0",
                     {cfg_rdy, mem_cfg_set, mem_pop, ker_val, ker_last, ker_end, done}, ker_data, mem_cfg_start, mem_cfg_end);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_idle: cfg_rdy=%b want 1", cfg_rdy); end
    endtask

    task automatic test_single_pass();
        run_job(16'd4, 16'd7, 16'd1, 100, 0, "single_pass");
    endtask

    task automatic test_multi_pass();
        run_job(16'd0, 16'd2, 16'd3, 100, 0, "multi_pass");
    endtask

    task automatic test_wrap();
        run_job(16'hFFFE, 16'h0001, 16'd1, 100, 0, "wrap");
    endtask

    task automatic test_random_stall();
        run_job(16'd0, 16'd9, 16'd1, 50, 0, "stall50");
        run_job(16'd20, 16'd24, 16'd2, 30, 0, "stall30");
    endtask

    task automatic test_reset_mid_job();
        run_job(16'd0, 16'd9, 16'd1, 100, 3, "mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ker_rdy = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({cfg_rdy, mem_cfg_set, mem_pop, ker_val, ker_last, ker_end, done} !== 7'b1000000 ||
            ker_data !== 64'd0 || mem_cfg_start !== 16'd0 || mem_cfg_end !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset_values: flags=%b data=%h start=%h end=%h want 1000000 0 0 0",
                     {cfg_rdy, mem_cfg_set, mem_pop, ker_val, ker_last, ker_end, done}, ker_data, mem_cfg_start, mem_cfg_end);
        end
        @(negedge clk);
        rst = 1'b0;
        run_job(16'd5, 16'd5, 16'd1, 100, 0, "after_reset");
    endtask

    task automatic test_repeat_zero();
        run_job(16'd8, 16'd8, 16'd0, 100, 0, "repeat_zero");
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        for (int j = 0; j < 6; j++) begin
            s = 16'($urandom);
            run_job(s, s + 16'($urandom_range(11, 0)), 16'($urandom_range(3, 0)),
                    int'($urandom_range(100, 20)), 0, "random_job");
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_wrap();
        test_random_stall();
        test_reset_mid_job();
        test_repeat_zero();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kernel_seq.md
# kernel_seq

Read-side sequencer for the per-group kernel memory. Accepts a job (address range plus pass count), programs the memory's read window, and pops words with its one-cycle read latency. Presents kernel words to the convolution array as a valid/ready stream with pass markers. Sits between the layer controller and the compute group, opposite the kernel loader on the memory's write side.

## Interface
- GROUP_NB, 4, kernels per convolution group (lanes per word)
- KER_WIDTH, 16, bits per kernel value
- MEM_AWIDTH, 16, kernel memory address width
- RPT_WIDTH, 16, pass-count width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  MEM_AWIDTH  first address of kernel range
- cfg_end  in  MEM_AWIDTH  last address of range, inclusive
- cfg_repeat  in  RPT_WIDTH  number of passes over the range; 0 is treated as 1
- cfg_val  in  1  job request
- cfg_rdy  out  1  high only in IDLE
- mem_cfg_start  out  MEM_AWIDTH  read window start, to memory
- mem_cfg_end  out  MEM_AWIDTH  read window end, to memory
- mem_cfg_set  out  1  one-cycle window load strobe
- mem_data  in  GROUP_NB*KER_WIDTH  memory read data, valid the cycle after a pop
- mem_pop  out  1  read-advance strobe
- ker_data  out  GROUP_NB*KER_WIDTH  kernel word to array
- ker_val  out  1  ker_data valid
- ker_rdy  in  1  array accepts word
- ker_last  out  1  word is last of a pass
- ker_end  out  1  word is last of the job
- done  out  1  one-cycle pulse after final word accepted

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE: cfg_rdy=1. On cfg_val, latch start/end/repeat and go to LOAD.
- LOAD: one cycle; mem_cfg_set=1 with latched start/end; go to STREAM.
- STREAM: issue mem_pop while pops remain and FIFO credit allows. After the last pop, go to DRAIN.
- DRAIN: wait until FIFO is empty and no pop is in flight; pulse done; go to IDLE.
- Pass length = (cfg_end - cfg_start + 1) mod 2^MEM_AWIDTH, where 0 means 2^MEM_AWIDTH. The range may wrap past address MEM_DEPTH-1.
- Total pops = pass length × passes. No re-program between passes; the memory rewinds to start after end on its own.
- Output buffer is a 2-entry FIFO. Credit = stored entries + in-flight pop (issued the previous cycle) − same-cycle dequeue. Pop only when credit < 2.
- Never overflow. Sustain 1 word/cycle while ker_rdy is held high.
- Data captured from mem_data the cycle after each pop. Tags are computed at pop time and stored with the word.
- ker_data/ker_last/ker_end are held stable while ker_val=1 and ker_rdy=0.
- cfg_val outside IDLE is ignored.

## Timing
- Reset values: cfg_rdy=1 (on the cycle after reset deasserts); mem_cfg_set=0, mem_pop=0, ker_val=0, ker_last=0, ker_end=0, done=0, ker_data=0, mem_cfg_start=0, mem_cfg_end=0.
- cfg handshake at cycle T:
  - mem_cfg_set at T+1.
  - First mem_pop no earlier than T+2.
  - First ker_val at T+3.
- done is asserted the cycle after the ker_val&ker_rdy handshake of the ker_end word. cfg_rdy rises that same cycle.
- Reset mid-job:
  - Next cycle: IDLE, FIFO cleared, counters zeroed, no pop or strobe.
  - The memory read pointer is not touched; the next job reprograms it.

## Configuration
- KERNEL_SEQ_LAST_EN defined: per-pass word counter is built; ker_last is driven as specified.
- Undefined: ker_last is tied 0 and the per-pass counter is removed. ker_end and done are unaffected.

## Test plan
- start=4, end=7, repeat=1, ker_rdy=1 -> mem_cfg_set at T+1; words from addr 4,5,6,7 on consecutive cycles from T+3; ker_last and ker_end on addr 7; done one cycle later.
- start=0, end=2, repeat=3, ker_rdy=1 -> 9 words, addr sequence 0,1,2 ×3; ker_last on words 3, 6, 9; ker_end only on word 9; single mem_cfg_set.
- start=0xFFFE, end=0x0001, repeat=1 -> 4 words from addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- start=0, end=9, ker_rdy random 50% -> no lost or duplicated words; data stable under stall; pops never exceed FIFO credit.
- Job of 10 words; assert rst after the 3rd word is accepted -> all outputs at reset values the next cycle; a new job start=5, end=5 returns exactly addr 5.
- cfg_repeat=0, start=end=8 -> exactly one word from addr 8, with ker_last=ker_end=1.
